// File: rtl/pulse_train_meter.sv
// Pulse-train meter: counts rising/falling edges and high/low samples of sig_in over a window of clk cycles.
// Optional glitch filter is compiled in with `define PULSE_TRAIN_METER_GLITCH_FILTER_EN.
module pulse_train_meter #(
    parameter int CNT_W       = 32,
    parameter int WIN_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] rise_count,
    output logic [CNT_W-1:0] fall_count,
    output logic [CNT_W-1:0] high_ticks,
    output logic [CNT_W-1:0] low_ticks,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_param_check
        $error("pulse_train_meter: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
    end

    state_t                 state;
    logic [WIN_W-1:0]       win_cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   f;
    logic                   f_d;
    logic                   rise;
    logic                   fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef PULSE_TRAIN_METER_GLITCH_FILTER_EN
    localparam int FC_W = $clog2(FILT_LEN + 1);

    logic [FC_W-1:0] filt_cnt;
    logic            f_q;

    // f only follows s once s has disagreed with it for FILT_LEN consecutive samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_cnt <= '0;
            f_q      <= 1'b0;
        end else if (s == f_q) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
            filt_cnt <= '0;
            f_q      <= s;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign f = f_q;
`else
    assign f = s;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) f_d <= 1'b0;
        else       f_d <= f;
    end

    assign rise = f & ~f_d;
    assign fall = ~f & f_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            win_cnt    <= '0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            rise_count <= '0;
            fall_count <= '0;
            high_ticks <= '0;
            low_ticks  <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        win_cnt    <= (win_len == '0) ? WIN_W'(1) : win_len;
                        rise_count <= '0;
                        fall_count <= '0;
                        high_ticks <= '0;
                        low_ticks  <= '0;
                        overflow   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= MEASURE;
                    end
                end
                MEASURE: begin
                    // saturating accumulate; any blocked increment latches overflow
                    if (f) begin
                        if (high_ticks == CNT_MAX) overflow <= 1'b1;
                        else                       high_ticks <= high_ticks + 1'b1;
                    end else begin
                        if (low_ticks == CNT_MAX) overflow <= 1'b1;
                        else                      low_ticks <= low_ticks + 1'b1;
                    end
                    if (rise) begin
                        if (rise_count == CNT_MAX) overflow <= 1'b1;
                        else                       rise_count <= rise_count + 1'b1;
                    end
                    if (fall) begin
                        if (fall_count == CNT_MAX) overflow <= 1'b1;
                        else                       fall_count <= fall_count + 1'b1;
                    end
                    win_cnt <= win_cnt - 1'b1;
                    if (win_cnt == WIN_W'(1)) begin
                        res_valid <= 1'b1;
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_meter.sv
// Bench for pulse_train_meter: table vectors, corner-case sequences and random windows vs. a sample-history model.
module tb_pulse_train_meter;

    localparam int CNT_W = 8;
    localparam int WIN_W = 32;
    localparam int SYNC  = 2;
    localparam int FILT  = 3;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sig_in = 1'b0;
    logic             start = 1'b0;
    logic [WIN_W-1:0] win_len = '0;
    logic             res_ready = 1'b0;
    logic             busy, res_valid, overflow;
    logic [CNT_W-1:0] rise_count, fall_count, high_ticks, low_ticks;

    pulse_train_meter #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SYNC_STAGES(SYNC), .FILT_LEN(FILT)) dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .start(start), .win_len(win_len),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .rise_count(rise_count), .fall_count(fall_count), .high_ticks(high_ticks),
        .low_ticks(low_ticks), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {int rise; int fall; int high; int low; int ovf;} res_t;
    typedef struct {int mode; int win; res_t exp;} vec_t;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // sig_in source: 0 low, 1 high, 2 3-high/7-low train, 3 random runs
    int mode = 0;
    int phase = 0;
    bit glitch_req = 1'b0;
    always @(negedge clk) begin
        phase = (phase + 1) % 10;
        case (mode)
            0: sig_in = 1'b0;
            1: sig_in = 1'b1;
            2: sig_in = (phase < 3);
            default: if ($urandom_range(0, 2) == 0) sig_in = ~sig_in;
        endcase
        if (glitch_req) begin
            sig_in = 1'b1;
            glitch_req = 1'b0;
        end
    end

    // sig_in as seen at each rising edge, indexed by edge number
    logic hist[int];
    int   ecnt = 0;
    always @(posedge clk) begin
        hist[ecnt] = sig_in;
        ecnt = ecnt + 1;
    end

    function automatic logic h(input int i);
        return (i >= 0 && hist.exists(i)) ? hist[i] : 1'b0;
    endfunction

    // Window accepted at edge t covers samples at edges t+1..t+n of the
    // conditioned signal (SYNC edges late, optionally run-length filtered).
    function automatic res_t model(input int t, input int n);
        res_t r;
        int   rr = 0, ff = 0, hh = 0, ll = 0;
        logic fv[];
        logic fc, fp;
`ifdef PULSE_TRAIN_METER_GLITCH_FILTER_EN
        logic cur = 1'b0;
        logic sv;
        int   run = 0;
`endif
        fv = new[t + n + 1];
        for (int j = 0; j <= t + n; j++) begin
`ifdef PULSE_TRAIN_METER_GLITCH_FILTER_EN
            sv = h(j - SYNC);
            run = (sv !== cur) ? run + 1 : 0;
            if (run >= FILT) begin
                cur = sv;
                run = 0;
            end
            fv[j] = cur;
`else
            fv[j] = h(j - SYNC + 1);
`endif
        end
        for (int k = t + 1; k <= t + n; k++) begin
            fc = fv[k - 1];
            fp = (k >= 2) ? fv[k - 2] : 1'b0;
            if (fc) hh++; else ll++;
            if (fc && !fp) rr++;
            if (!fc && fp) ff++;
        end
        r.ovf  = (rr > SAT || ff > SAT || hh > SAT || ll > SAT) ? 1 : 0;
        r.rise = (rr > SAT) ? SAT : rr;
        r.fall = (ff > SAT) ? SAT : ff;
        r.high = (hh > SAT) ? SAT : hh;
        r.low  = (ll > SAT) ? SAT : ll;
        return r;
    endfunction

    task automatic cmp_res(input string tag, input res_t got, input res_t exp);
        chk({tag, ".rise"}, got.rise, exp.rise);
        chk({tag, ".fall"}, got.fall, exp.fall);
        chk({tag, ".high"}, got.high, exp.high);
        chk({tag, ".low"},  got.low,  exp.low);
        chk({tag, ".ovf"},  got.ovf,  exp.ovf);
    endtask

    // One full window: start, latency, results vs model, hold under backpressure, handshake.
    task automatic run_window(input string tag, input int n_req, input int rdy_dly,
                              input int gl_at, input bit poke, output res_t got);
        int   t, neff, cnt;
        res_t exp;
        @(negedge clk);
        start   = 1'b1;
        win_len = n_req;
        @(negedge clk);
        start   = 1'b0;
        win_len = $urandom;
        t    = ecnt - 1;
        neff = (n_req == 0) ? 1 : n_req;
        chk({tag, ".busy_after_start"}, busy, 1'b1);
        cnt = 1;
        while (!res_valid && cnt < neff + 20) begin
            if (cnt == gl_at) glitch_req = 1'b1;
            @(negedge clk);
            cnt++;
        end
        chk({tag, ".latency"}, cnt, neff + 1);
        exp = model(t, neff);
        got.rise = rise_count;
        got.fall = fall_count;
        got.high = high_ticks;
        got.low  = low_ticks;
        got.ovf  = overflow;
        cmp_res(tag, got, exp);
        chk({tag, ".busy_report"}, busy, 1'b1);
        for (int i = 0; i < rdy_dly; i++) begin
            if (poke) start = (i == 1);
            @(negedge clk);
            start = 1'b0;
            chk({tag, ".hold_valid"}, res_valid, 1'b1);
            chk({tag, ".hold_high"}, high_ticks, exp.high);
            chk({tag, ".hold_rise"}, rise_count, exp.rise);
        end
        // start coinciding with the handshake cycle must be dropped
        res_ready = 1'b1;
        start     = poke;
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        chk({tag, ".valid_drop"}, res_valid, 1'b0);
        chk({tag, ".busy_drop"}, busy, 1'b0);
        if (poke) begin
            @(negedge clk);
            chk({tag, ".start_ignored"}, busy, 1'b0);
        end
    endtask

    initial begin
        vec_t tbl[6];
        res_t got, gexp;
        int   seen, m, w;

        tbl[0] = '{mode: 2, win: 100, exp: '{rise: 10, fall: 10, high: 30,  low: 70,  ovf: 0}};
        tbl[1] = '{mode: 0, win: 0,   exp: '{rise: 0,  fall: 0,  high: 0,   low: 1,   ovf: 0}};
        tbl[2] = '{mode: 1, win: 300, exp: '{rise: 0,  fall: 0,  high: SAT, low: 0,   ovf: 1}};
        tbl[3] = '{mode: 1, win: 5,   exp: '{rise: 0,  fall: 0,  high: 5,   low: 0,   ovf: 0}};
        tbl[4] = '{mode: 0, win: 255, exp: '{rise: 0,  fall: 0,  high: 0,   low: SAT, ovf: 0}};
        tbl[5] = '{mode: 0, win: 256, exp: '{rise: 0,  fall: 0,  high: 0,   low: SAT, ovf: 1}};

        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 1'b0);
        chk("rst.valid", res_valid, 1'b0);
        chk("rst.ovf", overflow, 1'b0);
        chk("rst.rise", rise_count, 0);
        chk("rst.high", high_ticks, 0);
        chk("rst.low", low_ticks, 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            mode = tbl[i].mode;
            repeat (30) @(negedge clk);
            run_window($sformatf("tbl%0d", i), tbl[i].win, 0, -1, 1'b0, got);
            cmp_res($sformatf("tbl%0d.const", i), got, tbl[i].exp);
        end

        // backpressure with a start pulse during REPORT and at the handshake
        mode = 2;
        repeat (10) @(negedge clk);
        run_window("bp", 20, 5, -1, 1'b1, got);

        // reset mid-window aborts with no result
        @(negedge clk);
        start   = 1'b1;
        win_len = 100;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        mode  = 0;
        reset = 1'b1;
        #1;
        chk("midrst.busy", busy, 1'b0);
        chk("midrst.valid", res_valid, 1'b0);
        chk("midrst.low", low_ticks, 0);
        chk("midrst.high", high_ticks, 0);
        chk("midrst.fall", fall_count, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        chk("midrst.no_result", seen, 0);
        mode = 2;
        repeat (10) @(negedge clk);
        run_window("postrst", 40, 0, -1, 1'b0, got);
        gexp = '{rise: 4, fall: 4, high: 12, low: 28, ovf: 0};
        cmp_res("postrst.const", got, gexp);

        // single-cycle glitch inside a low window
        mode = 0;
        repeat (20) @(negedge clk);
        run_window("glitch", 50, 0, 10, 1'b0, got);
`ifdef PULSE_TRAIN_METER_GLITCH_FILTER_EN
        gexp = '{rise: 0, fall: 0, high: 0, low: 50, ovf: 0};
`else
        gexp = '{rise: 1, fall: 1, high: 1, low: 49, ovf: 0};
`endif
        cmp_res("glitch.const", got, gexp);

        for (int i = 0; i < 25; i++) begin
            m = $urandom_range(0, 3);
            mode = (m == 0) ? 3 : m;
            w = ($urandom_range(0, 4) == 0) ? $urandom_range(200, 300) : $urandom_range(0, 60);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_window($sformatf("rnd%0d", i), w, $urandom_range(0, 3), -1, $urandom_range(0, 1), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
